// File: rtl/adc_sched_pkg.sv
// rtl/adc_sched_pkg.sv - shared FSM encoding, source/channel constants and parameter defaults
package adc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_REQ0 = 2'd1,
    SRC_REQ1 = 2'd2,
    SRC_AUTO = 2'd3
  } src_e;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam logic [15:0] SAMPLE_DIV_DEF = 16'd5000;
  localparam logic [10:0] TIMEOUT_DEF    = 11'd1024;

endpackage

// File: rtl/adc_rr_arbiter.sv
// rtl/adc_rr_arbiter.sv - round-robin pick between req0/req1, auto-trigger only when both are idle
module adc_rr_arbiter
  import adc_sched_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic auto_i,
  output src_e grant_o,
  output logic ch_o
);

  // prio1_q set means req1 wins a tie; cleared after reset so req0 goes first
  logic prio1_q, prio1_d;
  logic auto_ch_q, auto_ch_d;

  always_comb begin
    grant_o   = SRC_NONE;
    ch_o      = CH0;
    prio1_d   = prio1_q;
    auto_ch_d = auto_ch_q;
    if (en_i) begin
      if (req0_i && (!req1_i || !prio1_q)) begin
        grant_o = SRC_REQ0;
        ch_o    = CH0;
        prio1_d = 1'b1;
      end else if (req1_i) begin
        grant_o = SRC_REQ1;
        ch_o    = CH1;
        prio1_d = 1'b0;
      end else if (auto_i) begin
        grant_o   = SRC_AUTO;
        ch_o      = auto_ch_q;
        auto_ch_d = ~auto_ch_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio1_q   <= 1'b0;
      auto_ch_q <= CH0;
    end else begin
      prio1_q   <= prio1_d;
      auto_ch_q <= auto_ch_d;
    end
  end

endmodule

// File: rtl/adc_sample_scheduler.sv
// rtl/adc_sample_scheduler.sv - schedules ADC conversions for two requesters; ADC_SCHED_AUTO_EN adds a periodic auto-trigger
module adc_sample_scheduler
  import adc_sched_pkg::*;
#(
  parameter logic [15:0] SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter logic [10:0] TIMEOUT    = TIMEOUT_DEF
) (
  input  logic       CLK_50MHz,
  input  logic       RESET,
  input  logic       req0,
  input  logic       req1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] sample_out,
  output logic       sample_ch,
  output logic       auto_valid,
  output logic       conv_start,
  output logic       conv_ch,
  input  logic       conv_done,
  input  logic [7:0] conv_data,
  output logic       err
);

  state_e      state_q;
  src_e        src_q;
  src_e        grant;
  logic        grant_ch;
  logic        auto_pend;
  logic [10:0] tmo_q;
  logic        ack0_q, ack1_q, auto_valid_q, conv_start_q, conv_ch_q, sample_ch_q, err_q;
  logic [7:0]  sample_out_q;

  adc_rr_arbiter u_arb (
    .clk_i  (CLK_50MHz),
    .rst_ni (RESET),
    .en_i   (state_q == IDLE),
    .req0_i (req0),
    .req1_i (req1),
    .auto_i (auto_pend),
    .grant_o(grant),
    .ch_o   (grant_ch)
  );

`ifdef ADC_SCHED_AUTO_EN
  logic [15:0] div_q;
  logic        auto_pend_q;
  logic        wrap;

  assign wrap = (div_q == SAMPLE_DIV - 16'd1);

  // A wrap while a trigger is still pending is absorbed, never queued
  always_ff @(posedge CLK_50MHz or negedge RESET) begin
    if (!RESET) begin
      div_q       <= 16'd0;
      auto_pend_q <= 1'b0;
    end else begin
      div_q       <= wrap ? 16'd0 : div_q + 16'd1;
      auto_pend_q <= wrap | (auto_pend_q & (grant != SRC_AUTO));
    end
  end

  assign auto_pend = auto_pend_q;
`else
  logic [15:0] unused_div;
  assign unused_div = SAMPLE_DIV;
  assign auto_pend  = 1'b0;
`endif

  always_ff @(posedge CLK_50MHz or negedge RESET) begin
    if (!RESET) begin
      state_q      <= IDLE;
      src_q        <= SRC_NONE;
      tmo_q        <= 11'd0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      auto_valid_q <= 1'b0;
      conv_start_q <= 1'b0;
      conv_ch_q    <= CH0;
      sample_out_q <= 8'd0;
      sample_ch_q  <= CH0;
      err_q        <= 1'b0;
    end else begin
      conv_start_q <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      auto_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant != SRC_NONE) begin
            src_q        <= grant;
            conv_ch_q    <= grant_ch;
            conv_start_q <= 1'b1;
            state_q      <= START;
          end
        end
        START: begin
          tmo_q   <= 11'd1;
          state_q <= WAIT;
        end
        WAIT: begin
          // tmo_q equals cycles elapsed since conv_start, so err lands exactly TIMEOUT cycles after it
          if (conv_done) begin
            sample_out_q <= conv_data;
            sample_ch_q  <= conv_ch_q;
            ack0_q       <= (src_q == SRC_REQ0);
            ack1_q       <= (src_q == SRC_REQ1);
            auto_valid_q <= (src_q == SRC_AUTO);
            state_q      <= DONE;
          end else if (tmo_q == TIMEOUT - 11'd1) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 11'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign auto_valid = auto_valid_q;
  assign conv_start = conv_start_q;
  assign conv_ch    = conv_ch_q;
  assign sample_out = sample_out_q;
  assign sample_ch  = sample_ch_q;
  assign err        = err_q;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// tb/tb_adc_sample_scheduler.sv - randomized bench with a timestamp-based reference model and directed scenarios
module tb_adc_sample_scheduler;

  localparam int TO = 1024;
  localparam int SD = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       conv_done = 1'b0;
  logic [7:0] conv_data = 8'd0;
  logic       ack0, ack1, sample_ch, auto_valid, conv_start, conv_ch, err;
  logic [7:0] sample_out;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always #10 clk = ~clk;

  adc_sample_scheduler #(.SAMPLE_DIV(16'(SD)), .TIMEOUT(11'(TO))) dut (
    .CLK_50MHz (clk),
    .RESET     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .ack0      (ack0),
    .ack1      (ack1),
    .sample_out(sample_out),
    .sample_ch (sample_ch),
    .auto_valid(auto_valid),
    .conv_start(conv_start),
    .conv_ch   (conv_ch),
    .conv_done (conv_done),
    .conv_data (conv_data),
    .err       (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a transaction is granted from the inputs seen in an idle cycle,
  // starts the next cycle, then ends by conv_done (ack next cycle) or by timeout.
  int   busy = 0, tr_start = 0, done_at = 0, tr_src = 0, last = 1, win = -1;
  bit   m_auto_ch = 0, m_pend = 0;
  int   m_div = 0;
  bit   e_start = 0, e_ch = 0, e_ack0 = 0, e_ack1 = 0, e_av = 0, e_sch = 0, e_err = 0;
  logic [7:0] e_sample = 8'd0;

  always @(posedge clk) begin
    cyc++;
    e_start = 0; e_ack0 = 0; e_ack1 = 0; e_av = 0;
    win = -1;
    if (!rst_n) begin
      busy = 0; done_at = 0; last = 1; m_auto_ch = 0; m_pend = 0; m_div = 0;
      e_ch = 0; e_sch = 0; e_err = 0; e_sample = 8'd0;
    end else begin
      if (busy == 0) begin
        if (req0 && req1) win = (last == 0) ? 1 : 0;
        else if (req0)    win = 0;
        else if (req1)    win = 1;
        else if (m_pend)  win = 2;
        if (win >= 0) begin
          busy = 1; tr_start = cyc; done_at = 0; tr_src = win; e_start = 1;
          if (win < 2) begin
            e_ch = win[0];
            last = win;
          end else begin
            e_ch = m_auto_ch;
            m_auto_ch = !m_auto_ch;
          end
        end
      end else if (done_at != 0) begin
        busy = 0;
      end else if (cyc - 1 > tr_start) begin
        if (conv_done) begin
          done_at = cyc; e_sample = conv_data; e_sch = e_ch;
          e_ack0 = (tr_src == 0); e_ack1 = (tr_src == 1); e_av = (tr_src == 2);
        end else if (cyc - 1 - tr_start == TO - 1) begin
          e_err = 1; busy = 0;
        end
      end
`ifdef ADC_SCHED_AUTO_EN
      m_pend = (m_div == SD - 1) || (m_pend && win != 2);
      m_div = (m_div == SD - 1) ? 0 : m_div + 1;
`endif
    end
  end

  bit saw_start = 0, saw_ack0 = 0, saw_ack1 = 0;

  always @(negedge clk) begin
    saw_start = conv_start;
    saw_ack0  = ack0;
    saw_ack1  = ack1;
    if (!rst_n)
      check("reset_state", {ack0, ack1, auto_valid, conv_start, conv_ch, sample_ch, err, sample_out}, 32'd0);
    else
      check("cycle_outputs", {ack0, ack1, auto_valid, conv_start, conv_ch, sample_ch, err, sample_out},
            {e_ack0, e_ack1, e_av, e_start, e_ch, e_sch, e_err, e_sample});
  end

  // Conversion engine: answers each conv_start after eng_d cycles (0 = never); random mode also
  // injects stray conv_done pulses.
  bit         eng_fix = 1;
  int         eng_d = 5;
  logic [7:0] eng_data = 8'h00;
  int         eng_cnt = 0;

  always @(posedge clk) begin
    #1;
    conv_done = 1'b0;
    if (saw_start) begin
      if (eng_fix) eng_cnt = eng_d;
      else eng_cnt = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 60));
    end
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        conv_done = 1'b1;
        conv_data = eng_fix ? eng_data : 8'($urandom);
      end
    end else if (!eng_fix && $urandom_range(0, 99) == 0) begin
      conv_done = 1'b1;
      conv_data = 8'($urandom);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // which: 0 conv_start, 1 ack0, 2 ack1, 3 err, 4 auto_valid, 5 any ack, 6 any result
  task automatic wait_evt(input int which, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0 && conv_start) || (which == 1 && ack0) || (which == 2 && ack1) ||
          (which == 3 && err) || (which == 4 && auto_valid) || (which == 5 && (ack0 || ack1)) ||
          (which == 6 && (ack0 || ack1 || auto_valid))) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_event_%0d: not seen within %0d cycles", which, budget);
    end
  endtask

  int t, t2, t3, n, got, nack, tp;

  initial begin
    // Single request, 40-cycle conversion
    eng_fix = 1; eng_d = 40; eng_data = 8'hA5;
    do_reset();
    tick(); req0 = 1'b1; n = cyc;
    wait_evt(0, 10, t);
    check("t033_start_latency", t, n + 1);
    check("t033_conv_ch", conv_ch, 0);
    wait_evt(1, 100, t2);
    check("t033_ack_latency", t2, t + 41);
    check("t033_sample_out", sample_out, 8'hA5);
    check("t033_sample_ch", sample_ch, 0);
    tick(); req0 = 1'b0;

    // Simultaneous requests, two rounds
    eng_d = 5; eng_data = 8'h11;
    do_reset();
    tick(); req0 = 1'b1; req1 = 1'b1;
    for (int r = 0; r < 4; r++) begin
      wait_evt(5, 200, t);
      got = ack1 ? 1 : 0;
      check("t034_grant_order", got, r % 2);
      check("t034_no_overlap", ack0 & ack1, 0);
      tick();
      if (got == 1) req1 = 1'b0; else req0 = 1'b0;
      if (r == 1) begin req0 = 1'b1; req1 = 1'b1; end
    end

    // Engine never answers
    eng_d = 0;
    do_reset();
    tick(); req1 = 1'b1;
    wait_evt(0, 10, t);
    check("t035_conv_ch", conv_ch, 1);
    wait_evt(3, TO + 10, t2);
    check("t035_err_time", t2 - t, TO);
    check("t035_no_sample", sample_out, 0);
    wait_evt(0, 10, t3);
    check("t035_restart", t3, t2 + 1);
    check("t035_restart_ch", conv_ch, 1);
    do_reset();
    check("t035_err_cleared", err, 0);

    // Reset in WAIT, late conv_done must be ignored
    eng_d = 20; eng_data = 8'h3C;
    tick(); req0 = 1'b1;
    wait_evt(0, 10, t);
    repeat (5) tick();
    rst_n = 1'b0; req0 = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    nack = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (ack0 || ack1 || conv_start) nack++;
    end
    check("t036_no_ack", nack, 0);
    check("t036_sample_zero", sample_out, 0);
    eng_data = 8'h5A;
    tick(); req1 = 1'b1;
    wait_evt(2, 100, t);
    check("t036_next_sample", sample_out, 8'h5A);
    check("t036_next_ch", sample_ch, 1);
    tick(); req1 = 1'b0;

`ifdef ADC_SCHED_AUTO_EN
    eng_d = 10; eng_data = 8'h77;
    do_reset();
    n = cyc; tp = 0;
    for (int k = 0; k < 4; k++) begin
      wait_evt(0, 150, t);
      if (k == 0) check("t037_first_start", t, n + 101);
      else check("t037_period", t - tp, SD);
      check("t037_auto_ch", conv_ch, k % 2);
      tp = t;
      wait_evt(4, 20, t2);
      check("t037_valid_latency", t2, t + 11);
    end
    eng_d = 150;
    wait_evt(0, 150, t);
    tick(); req0 = 1'b1; eng_d = 10;
    wait_evt(4, 200, t2);
    wait_evt(6, 50, t3);
    check("t037_req0_first", ack0, 1);
    tick(); req0 = 1'b0;
    wait_evt(4, 50, t3);
`endif

    // Random traffic with a mid-run reset
    eng_fix = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (i == 2000) rst_n = 1'b0;
      if (i == 2002) rst_n = 1'b1;
      if (req0) begin
        if (saw_ack0 || $urandom_range(0, 63) == 0) req0 = 1'b0;
      end else if ($urandom_range(0, 5) == 0) req0 = 1'b1;
      if (req1) begin
        if (saw_ack1 || $urandom_range(0, 63) == 0) req1 = 1'b0;
      end else if ($urandom_range(0, 5) == 0) req1 = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
